// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 registered demultiplexer.
// The one-hot decode lives here so the datapath and any checker use the same
// mapping from select code to channel.
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  // Select code to one-hot channel enable: 0 -> 4'b0001 ... 3 -> 4'b1000.
  function automatic logic [NUM_OUT-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NUM_OUT-1:0] dec;
    dec      = '0;
    dec[sel] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One output channel of the demultiplexer.
// Loads d when selected. Otherwise it clears rather than holding, so a channel
// only carries data in the cycle after it was the selected destination.
module demux_out_reg
  import demux_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  // Load when selected, clear otherwise; reset clears without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= '0;
    end
  end

endmodule

// File: rtl/demux_1to4_if.sv
// Registered 1-to-4 data demultiplexer.
// The word on i is steered to the channel chosen by sel. The other three
// channels are driven to zero, and out_valid carries a one-hot flag for the
// loaded channel. There is one register stage, no backpressure and no storage
// beyond the output registers.
module demux_1to4_if
  import demux_pkg::*;
#(
  parameter int width = 8,
  parameter int snum  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] i,
  input  logic [snum-1:0]  sel,
  input  logic             in_valid,
  output logic [width-1:0] o0,
  output logic [width-1:0] o1,
  output logic [width-1:0] o2,
  output logic [width-1:0] o3,
  output logic [3:0]       out_valid
);

  // Four outputs need exactly a 2-bit select, and a zero-width data path is meaningless.
  if (snum != SEL_W) begin : g_bad_snum
    $error("demux_1to4_if: snum must be %0d, got %0d", SEL_W, snum);
  end
  if (width < 1) begin : g_bad_width
    $error("demux_1to4_if: width must be >= 1, got %0d", width);
  end

  logic [SEL_W-1:0]   sel_dec;
  logic               sel_known;
  logic [NUM_OUT-1:0] load_vec;
  logic [width-1:0]   o_arr [NUM_OUT];

  assign sel_dec = SEL_W'(sel);

  // An X/Z select routes nothing. Synthesis sees sel as always known, so this
  // guard only changes behaviour in simulation.
  assign sel_known = !$isunknown(sel);

  // A single decode drives both the channel loads and out_valid, so the data
  // and its qualifier can never disagree.
  assign load_vec = (in_valid && sel_known) ? onehot4(sel_dec) : '0;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
    demux_out_reg #(
      .width(width)
    ) u_out_reg (
      .clk (clk),
      .rst (rst),
      .load(load_vec[k]),
      .d   (i),
      .q   (o_arr[k])
    );
  end

  assign o0 = o_arr[0];
  assign o1 = o_arr[1];
  assign o2 = o_arr[2];
  assign o3 = o_arr[3];

  // Register the per-channel valid in step with the data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
    end else begin
      out_valid <= load_vec;
    end
  end

endmodule

// File: tb/tb_demux_1to4_if.sv
// Directed bench for demux_1to4_if. It checks reset, routing, qualification,
// back-to-back loads and mid-stream reset on an 8-bit instance, plus a 16-bit instance.
module tb_demux_1to4_if;

  int checks   = 0;
  int failures = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i   = '0;
  logic [1:0] sel = '0;
  logic       in_valid = 1'b0;
  logic [7:0] o0, o1, o2, o3;
  logic [3:0] out_valid;

  logic [15:0] i16   = '0;
  logic [1:0]  sel16 = '0;
  logic        v16   = 1'b0;
  logic [15:0] p0, p1, p2, p3;
  logic [3:0]  ov16;

  always #5 clk = ~clk;

  demux_1to4_if #(.width(8), .snum(2)) dut (
    .clk(clk), .rst(rst), .i(i), .sel(sel), .in_valid(in_valid),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .out_valid(out_valid)
  );

  demux_1to4_if #(.width(16), .snum(2)) dut16 (
    .clk(clk), .rst(rst), .i(i16), .sel(sel16), .in_valid(v16),
    .o0(p0), .o1(p1), .o2(p2), .o3(p3), .out_valid(ov16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] ev);
    chk({tag, ".o0"}, 32'(o0), 32'(e0));
    chk({tag, ".o1"}, 32'(o1), 32'(e1));
    chk({tag, ".o2"}, 32'(o2), 32'(e2));
    chk({tag, ".o3"}, 32'(o3), 32'(e3));
    chk({tag, ".ov"}, 32'(out_valid), 32'(ev));
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic v);
    @(negedge clk);
    i = d; sel = s; in_valid = v;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a live vector present: nothing may load.
    i = 8'hFF; sel = 2'd2; in_valid = 1'b1;
    #3;
    chk8("rst_async", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    edge_sample();
    chk8("rst_held", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    chk8("rst_first", 8'h00, 8'h00, 8'hFF, 8'h00, 4'b0100);

    // One value per edge to each channel.
    drive(8'hA0, 2'd0, 1'b1); edge_sample();
    chk8("sw0", 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001);
    drive(8'hB0, 2'd1, 1'b1); edge_sample();
    chk8("sw1", 8'h00, 8'hB0, 8'h00, 8'h00, 4'b0010);
    drive(8'hC0, 2'd2, 1'b1); edge_sample();
    chk8("sw2", 8'h00, 8'h00, 8'hC0, 8'h00, 4'b0100);
    drive(8'hD0, 2'd3, 1'b1); edge_sample();
    chk8("sw3", 8'h00, 8'h00, 8'h00, 8'hD0, 4'b1000);

    // When the word is not qualified, every channel clears.
    drive(8'h5A, 2'd1, 1'b0); edge_sample();
    chk8("qual_lo", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    drive(8'h5A, 2'd1, 1'b1); edge_sample();
    chk8("qual_hi", 8'h00, 8'h5A, 8'h00, 8'h00, 4'b0010);

    // Same channel on back-to-back edges.
    drive(8'h11, 2'd3, 1'b1); edge_sample();
    chk8("b2b_11", 8'h00, 8'h00, 8'h00, 8'h11, 4'b1000);
    drive(8'h22, 2'd3, 1'b1); edge_sample();
    chk8("b2b_22", 8'h00, 8'h00, 8'h00, 8'h22, 4'b1000);
    drive(8'h33, 2'd3, 1'b1); edge_sample();
    chk8("b2b_33", 8'h00, 8'h00, 8'h00, 8'h33, 4'b1000);

    // Reset pulse between edges while o1 holds data.
    drive(8'hB0, 2'd1, 1'b1); edge_sample();
    chk8("mid_pre", 8'h00, 8'hB0, 8'h00, 8'h00, 4'b0010);
    #1;
    rst = 1'b1;
    #1;
    chk8("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    #1;
    rst = 1'b0;
    #1;
    chk8("mid_rel", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    drive(8'h77, 2'd2, 1'b1); edge_sample();
    chk8("mid_resume", 8'h00, 8'h00, 8'h77, 8'h00, 4'b0100);

    // 16-bit instance.
    @(negedge clk);
    i16 = 16'hA000; sel16 = 2'd0; v16 = 1'b1;
    edge_sample();
    chk("w16.o0", 32'(p0), 32'h0000_A000);
    chk("w16.o1", 32'(p1), 32'h0);
    chk("w16.o2", 32'(p2), 32'h0);
    chk("w16.o3", 32'(p3), 32'h0);
    chk("w16.ov", 32'(ov16), 32'h1);
    @(negedge clk);
    i16 = 16'hBEEF; sel16 = 2'd3;
    edge_sample();
    chk("w16b.o0", 32'(p0), 32'h0);
    chk("w16b.o3", 32'(p3), 32'h0000_BEEF);
    chk("w16b.ov", 32'(ov16), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
